// File: rtl/approx_mult_pkg.sv
// Shared helpers for approx_mult_pipe: the product-width helper, the mode encoding
// and the lossy OR-exchange / truncation rule applied to the low multiplier rows.
package approx_mult_pkg;

  localparam int MAX_W    = 32;
  localparam int PW_MAX   = 2 * MAX_W;

  typedef enum logic {
    MODE_APPROX = 1'b0,
    MODE_EXACT  = 1'b1
  } mult_mode_e;

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  // Bit (row, col) of the partial-product array; anything outside the array reads as 0.
  function automatic logic pp_bit(input logic [MAX_W-1:0] x, input logic [MAX_W-1:0] y,
                                  input int row, input int col, input int width);
    logic [MAX_W-1:0] xs;
    logic [MAX_W-1:0] ys;
    logic             r;
    xs = x >> row;
    ys = y >> col;
    r  = 1'b0;
    if (row >= 0 && row < width && col >= 0 && col < width) begin
      r = xs[0] & ys[0];
    end
    return r;
  endfunction

  function automatic logic [PW_MAX-1:0] approx_contrib(input logic [MAX_W-1:0] x,
                                                       input logic [MAX_W-1:0] y,
                                                       input int width,
                                                       input int approx_l,
                                                       input int trunc_col);
    logic [PW_MAX-1:0] acc;
    logic [PW_MAX-1:0] col_bits;
    logic              a;
    logic              b;
    acc = '0;
    for (int r = 0; r < MAX_W; r += 2) begin
      col_bits = '0;
      if (r < approx_l) begin
        // A trailing odd row has no partner, so b stays 0 and its bits pass unchanged.
        for (int c = 0; c < PW_MAX; c++) begin
          a = pp_bit(x, y, r, c - r, width);
          b = (r + 1 < approx_l) ? pp_bit(x, y, r + 1, c - r - 1, width) : 1'b0;
          if (c >= trunc_col) begin
            col_bits = col_bits | (PW_MAX'(a | b) << c);
          end
        end
      end
      acc = acc + col_bits;
    end
    return acc;
  endfunction

endpackage

// File: rtl/approx_mult_pipe_compress.sv
// approx_pp_compress: combinational front end producing the two sum operands
// (exact upper-row product and either the compressed or the exact low-row product).
module approx_pp_compress
  import approx_mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int APPROX_L  = 6,
  parameter int TRUNC_COL = WIDTH - 1
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               mode_exact,
  output logic [2*WIDTH-1:0] op_hi,
  output logic [2*WIDTH-1:0] op_lo
);

  localparam int PW = prod_w(WIDTH);
  localparam logic [WIDTH-1:0] LO_MASK = {WIDTH{1'b1}} >> (WIDTH - APPROX_L);

  logic [WIDTH-1:0] x_hi;
  logic [WIDTH-1:0] x_lo;
  logic [PW-1:0]    exact_lo;
  logic [PW-1:0]    approx_lo;

  assign x_hi = x >> APPROX_L;
  assign x_lo = x & LO_MASK;

  assign op_hi     = (PW'(x_hi) * PW'(y)) << APPROX_L;
  assign exact_lo  = PW'(x_lo) * PW'(y);
  assign approx_lo = PW'(approx_contrib(MAX_W'(x), MAX_W'(y), WIDTH, APPROX_L, TRUNC_COL));

  // Both modes share the upper-row product, so only the low operand is selected.
  assign op_lo = mode_exact ? exact_lo : approx_lo;

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: pipelined unsigned approximate multiplier behind valid/ready streams.
// Define ERROR_STATS_EN to add stat_clr, err_cnt and err_max error statistics.
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_L    = 6,
  parameter int TRUNC_COL   = WIDTH - 1,
  parameter int PIPE_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               mode_exact,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z
`ifdef ERROR_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        err_cnt,
  output logic [2*WIDTH-1:0] err_max
`endif
);

  localparam int PW   = prod_w(WIDTH);
  localparam int LAST = PIPE_STAGES - 1;

  typedef struct packed {
    logic [PW-1:0]    z_partial;
    logic [PW-1:0]    addend;
    mult_mode_e       mode;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } stage_t;

  stage_t                 stage_data [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] stage_valid;
  logic [PIPE_STAGES-1:0] advance;
  logic [PW-1:0]          op_hi;
  logic [PW-1:0]          op_lo;

  approx_pp_compress #(
    .WIDTH     (WIDTH),
    .APPROX_L  (APPROX_L),
    .TRUNC_COL (TRUNC_COL)
  ) u_compress (
    .x          (x),
    .y          (y),
    .mode_exact (mode_exact),
    .op_hi      (op_hi),
    .op_lo      (op_lo)
  );

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    stage_t data_q;
    stage_t next_data;
    logic   valid_q;
    logic   next_valid;

    // A stage may load when it or any stage after it has room, or the output drains.
    assign advance[k] = out_ready || !(&stage_valid[LAST:k]);

    if (k == 0) begin : g_first
      assign next_valid = in_valid;
      assign next_data  = '{z_partial: op_hi,
                            addend:    op_lo,
                            mode:      mult_mode_e'(mode_exact),
                            x:         x,
                            y:         y};
    end else begin : g_next
      assign next_valid = stage_valid[k-1];
      assign next_data  = '{z_partial: stage_data[k-1].z_partial + stage_data[k-1].addend,
                            addend:    '0,
                            mode:      stage_data[k-1].mode,
                            x:         stage_data[k-1].x,
                            y:         stage_data[k-1].y};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (advance[k]) begin
        valid_q <= next_valid;
        if (next_valid) begin
          data_q <= next_data;
        end
      end
    end

    assign stage_valid[k] = valid_q;
    assign stage_data[k]  = data_q;
  end

  assign in_ready  = advance[0];
  assign out_valid = stage_valid[LAST];
  assign z         = stage_data[LAST].z_partial + stage_data[LAST].addend;

`ifdef ERROR_STATS_EN
  logic [PW-1:0] exact_prod;
  logic [PW-1:0] err_diff;
  logic          out_fire;

  assign out_fire   = out_valid && out_ready;
  assign exact_prod = PW'(stage_data[LAST].x) * PW'(stage_data[LAST].y);
  assign err_diff   = exact_prod - z;

  // A clear pulse wins over a simultaneous transfer, which is then not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (stat_clr) begin
      err_cnt <= '0;
      err_max <= '0;
    end else if (out_fire && stage_data[LAST].mode == MODE_APPROX && z != exact_prod) begin
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + 32'd1;
      end
      if (err_diff > err_max) begin
        err_max <= err_diff;
      end
    end
  end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench for approx_mult_pipe: directed corners, throughput, backpressure,
// mid-stream reset and 12-bit variants against a plain-arithmetic reference model.
module tb_approx_mult_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        mode_exact;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] z;

  logic        in_valid12;
  logic [11:0] x12;
  logic [11:0] y12;
  logic        mode12;
  logic        out_ready12;
  logic        in_ready_l0;
  logic        in_ready_l5;
  logic        out_valid_l0;
  logic        out_valid_l5;
  logic [23:0] z_l0;
  logic [23:0] z_l5;

`ifdef ERROR_STATS_EN
  logic        stat_clr;
  logic [31:0] err_cnt;
  logic [15:0] err_max;
  logic        stat_clr12;
  logic [31:0] err_cnt_l0;
  logic [31:0] err_cnt_l5;
  logic [23:0] err_max_l0;
  logic [23:0] err_max_l5;
`endif

  int n_cmp;
  int n_fail;
  int cyc;

  approx_mult_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .mode_exact (mode_exact),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .z          (z)
`ifdef ERROR_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .err_cnt    (err_cnt),
    .err_max    (err_max)
`endif
  );

  approx_mult_pipe #(.WIDTH(12), .APPROX_L(0)) dut_l0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid12),
    .in_ready   (in_ready_l0),
    .x          (x12),
    .y          (y12),
    .mode_exact (mode12),
    .out_valid  (out_valid_l0),
    .out_ready  (out_ready12),
    .z          (z_l0)
`ifdef ERROR_STATS_EN
    ,
    .stat_clr   (stat_clr12),
    .err_cnt    (err_cnt_l0),
    .err_max    (err_max_l0)
`endif
  );

  approx_mult_pipe #(.WIDTH(12), .APPROX_L(5)) dut_l5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid12),
    .in_ready   (in_ready_l5),
    .x          (x12),
    .y          (y12),
    .mode_exact (mode12),
    .out_valid  (out_valid_l5),
    .out_ready  (out_ready12),
    .z          (z_l5)
`ifdef ERROR_STATS_EN
    ,
    .stat_clr   (stat_clr12),
    .err_cnt    (err_cnt_l5),
    .err_max    (err_max_l5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact upper rows plus, per row pair, an OR of the two diagonal bits per kept column.
  function automatic longint pp(input longint xv, input longint yv, input int row, input int col, input int w);
    if (col < 0 || col >= w) return 0;
    return ((xv >> row) & 1) & ((yv >> col) & 1);
  endfunction

  function automatic longint ref_z(input longint xv, input longint yv, input bit exact,
                                   input int w, input int l, input int t);
    longint e;
    longint s;
    if (exact) return xv * yv;
    e = ((xv >> l) * yv) << l;
    s = 0;
    for (int r = 0; r < l; r += 2) begin
      for (int c = t; c < 2 * w; c++) begin
        longint a;
        longint b;
        a = pp(xv, yv, r, c - r, w);
        b = (r + 1 < l) ? pp(xv, yv, r + 1, c - r - 1, w) : 0;
        s += (a | b) << c;
      end
    end
    return e + s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one transaction into an empty pipeline and waits (bounded) for its result.
  task automatic send_one(input logic [7:0] xv, input logic [7:0] yv, input logic m,
                          output logic [15:0] zo, output int lat, output bit ok);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    x          = xv;
    y          = yv;
    mode_exact = m;
    tick();
    in_valid = 1'b0;
    ok  = 1'b0;
    zo  = '0;
    lat = 1;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        zo = z;
      end else begin
        tick();
        lat++;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_cmp++;
    if (z !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_z: got %0d expected 0", z); end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_out_valid: got %0b expected 0", out_valid); end
`ifdef ERROR_STATS_EN
    n_cmp++;
    if (err_cnt !== 32'd0 || err_max !== 16'd0) begin
      n_fail++; $display("[TB] FAIL reset_stats: got cnt %0d max %0d expected 0 0", err_cnt, err_max);
    end
`endif
  endtask

  task automatic test_directed();
    logic [7:0]  tx [8] = '{8'd255, 8'd255, 8'd128, 8'd128, 8'd0,   8'd93, 8'd1, 8'd1};
    logic [7:0]  ty [8] = '{8'd255, 8'd255, 8'd200, 8'd200, 8'd177, 8'd0,  8'd1, 8'd1};
    logic        tm [8] = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,  1'b0, 1'b1};
    logic [15:0] tz [8] = '{16'd59328, 16'd65025, 16'd25600, 16'd25600, 16'd0, 16'd0, 16'd0, 16'd1};
    logic [15:0] zo;
    int          lat;
    bit          ok;
`ifdef ERROR_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      send_one(tx[i], ty[i], tm[i], zo, lat, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++; $display("[TB] FAIL directed_timeout[%0d]: got no result expected z %0d", i, tz[i]);
      end else if (zo !== tz[i]) begin
        n_fail++; $display("[TB] FAIL directed_z[%0d] x=%0d y=%0d m=%0b: got %0d expected %0d", i, tx[i], ty[i], tm[i], zo, tz[i]);
      end
      n_cmp++;
      if (lat !== 2) begin n_fail++; $display("[TB] FAIL directed_latency[%0d]: got %0d expected 2", i, lat); end
`ifdef ERROR_STATS_EN
      if (i == 1) begin
        n_cmp++;
        if (err_cnt !== 32'd1 || err_max !== 16'd5697) begin
          n_fail++; $display("[TB] FAIL stats_255: got cnt %0d max %0d expected 1 5697", err_cnt, err_max);
        end
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q_z [$];
    int          q_c [$];
    logic [15:0] ez;
    int          ec;
    int          sent;
    int          got;
    logic        mv;
    sent      = 0;
    got       = 0;
    out_ready = 1'b1;
    for (int step = 0; step < 140; step++) begin
      if (sent == 100 && q_z.size() == 0) break;
      if (out_valid) begin
        if (q_z.size() == 0) begin
          n_cmp++; n_fail++; $display("[TB] FAIL b2b_duplicate: got out_valid 1 expected 0");
        end else begin
          ez = q_z.pop_front();
          ec = q_c.pop_front();
          got++;
          n_cmp++;
          if (z !== ez) begin n_fail++; $display("[TB] FAIL b2b_z: got %0d expected %0d", z, ez); end
          n_cmp++;
          if (cyc - ec !== 2) begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d expected 2", cyc - ec); end
        end
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_ready: got %0b expected 1", in_ready); end
      if (sent < 100) begin
        mv         = 1'($urandom_range(0, 1));
        in_valid   = 1'b1;
        x          = 8'($urandom_range(0, 255));
        y          = 8'($urandom_range(0, 255));
        mode_exact = mv;
        if (in_ready) begin
          q_z.push_back(16'(ref_z(longint'(x), longint'(y), mv, 8, 6, 7)));
          q_c.push_back(cyc);
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got !== 100) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 100", got); end
  endtask

  task automatic test_backpressure();
    logic [15:0] q_z [$];
    logic        prev_stall;
    logic [15:0] prev_z;
    logic        exp_ready;
    logic        mv;
    prev_stall = 1'b0;
    prev_z     = '0;
    for (int step = 0; step < 500; step++) begin
      if (step >= 200 && q_z.size() == 0) break;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || z !== prev_z) begin
          n_fail++; $display("[TB] FAIL stall_hold: got v=%0b z=%0d expected v=1 z=%0d", out_valid, z, prev_z);
        end
      end
      exp_ready = !(q_z.size() == 2 && !out_ready);
      n_cmp++;
      if (in_ready !== exp_ready) begin
        n_fail++; $display("[TB] FAIL bp_in_ready: got %0b expected %0b (in flight %0d)", in_ready, exp_ready, q_z.size());
      end
      if (q_z.size() == 2) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_full_out_valid: got %0b expected 1", out_valid); end
      end
      if (out_valid) begin
        n_cmp++;
        if (q_z.size() == 0) begin
          n_fail++; $display("[TB] FAIL bp_duplicate: got out_valid 1 expected 0");
        end else if (z !== q_z[0]) begin
          n_fail++; $display("[TB] FAIL bp_z: got %0d expected %0d", z, q_z[0]);
        end
        if (out_ready && q_z.size() != 0) void'(q_z.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_z     = z;
      mv         = 1'($urandom_range(0, 1));
      in_valid   = (step < 200);
      x          = 8'($urandom_range(0, 255));
      y          = 8'($urandom_range(0, 255));
      mode_exact = mv;
      if (in_valid && in_ready) q_z.push_back(16'(ref_z(longint'(x), longint'(y), mv, 8, 6, 7)));
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (q_z.size() != 0) begin n_fail++; $display("[TB] FAIL bp_drain: got %0d left expected 0", q_z.size()); end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] zo;
    int          lat;
    bit          ok;
    logic [15:0] ez;
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    x          = 8'd77;
    y          = 8'd99;
    mode_exact = 1'b1;
    tick();
    x = 8'd201;
    y = 8'd45;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mid_full: got v=%0b rdy=%0b expected v=1 rdy=0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || z !== 16'd0) begin
      n_fail++; $display("[TB] FAIL mid_async_reset: got v=%0b z=%0d expected v=0 z=0", out_valid, z);
    end
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_stale[%0d]: got out_valid 1 expected 0", i); end
      tick();
    end
    ez = 16'(ref_z(longint'(37), longint'(201), 1'b0, 8, 6, 7));
    send_one(8'd37, 8'd201, 1'b0, zo, lat, ok);
    n_cmp++;
    if (!ok || zo !== ez) begin
      n_fail++; $display("[TB] FAIL mid_first_after_reset: got ok=%0b z=%0d expected %0d", ok, zo, ez);
    end
  endtask

  task automatic test_width12();
    logic [11:0] qx [$];
    logic [11:0] qy [$];
    logic        qm [$];
    logic [11:0] ex;
    logic [11:0] ey;
    logic        em;
    logic [23:0] e0;
    logic [23:0] e5;
    int          sent;
    int          sel;
    sent        = 0;
    out_ready12 = 1'b1;
    for (int step = 0; step < 340; step++) begin
      if (sent == 300 && qx.size() == 0) break;
      if (out_valid_l0 || out_valid_l5) begin
        n_cmp++;
        if (out_valid_l0 !== out_valid_l5 || qx.size() == 0) begin
          n_fail++; $display("[TB] FAIL w12_valid: got v0=%0b v5=%0b pending %0d", out_valid_l0, out_valid_l5, qx.size());
        end else begin
          ex = qx.pop_front();
          ey = qy.pop_front();
          em = qm.pop_front();
          e0 = 24'(ref_z(longint'(ex), longint'(ey), em, 12, 0, 11));
          e5 = 24'(ref_z(longint'(ex), longint'(ey), em, 12, 5, 11));
          if (z_l0 !== e0 || z_l0 !== 24'(ex) * 24'(ey)) begin
            n_fail++; $display("[TB] FAIL w12_l0 x=%0d y=%0d: got %0d expected %0d", ex, ey, z_l0, e0);
          end
          n_cmp++;
          if (z_l5 !== e5) begin
            n_fail++; $display("[TB] FAIL w12_l5 x=%0d y=%0d m=%0b: got %0d expected %0d", ex, ey, em, z_l5, e5);
          end
        end
      end
      if (sent < 300) begin
        sel        = $urandom_range(0, 7);
        in_valid12 = 1'b1;
        x12        = (sel == 0) ? 12'hFFF : (sel == 1) ? 12'd0 : 12'($urandom_range(0, 4095));
        y12        = (sel == 2) ? 12'hFFF : 12'($urandom_range(0, 4095));
        mode12     = 1'($urandom_range(0, 1));
        if (in_ready_l0 && in_ready_l5) begin
          qx.push_back(x12);
          qy.push_back(y12);
          qm.push_back(mode12);
          sent++;
        end
      end else begin
        in_valid12 = 1'b0;
      end
      tick();
    end
    in_valid12 = 1'b0;
    n_cmp++;
    if (sent != 300 || qx.size() != 0) begin
      n_fail++; $display("[TB] FAIL w12_count: got sent %0d pending %0d expected 300 0", sent, qx.size());
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    x           = '0;
    y           = '0;
    mode_exact  = 1'b0;
    out_ready   = 1'b0;
    in_valid12  = 1'b0;
    x12         = '0;
    y12         = '0;
    mode12      = 1'b0;
    out_ready12 = 1'b1;
`ifdef ERROR_STATS_EN
    stat_clr    = 1'b0;
    stat_clr12  = 1'b0;
`endif
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_width12();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
